// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe_if.sv
// Handshake bundle for the pipelined AOI211 bank: operand vectors in, lane
// results out, plus the stage occupancy count.
interface gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
);
    localparam int OCCW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] ZN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [OCCW-1:0]  OCC;

    modport master (
        output A1, A2, B, C, IN_VALID, OUT_READY,
        input  IN_READY, ZN, OUT_VALID, OCC
    );

    modport slave (
        input  A1, A2, B, C, IN_VALID, OUT_READY,
        output IN_READY, ZN, OUT_VALID, OCC
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe.sv
// WIDTH-lane AOI211 / AO211 bank retimed through DEPTH stallable stages with
// bubble-collapsing valid/ready handshake and a registered occupancy count.
module gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 2,
    parameter int INVERT = 1
) (
    input  logic CLK,
    input  logic RN,
    gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe_if.slave bus
);
    localparam int OCCW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [OCCW-1:0]  r_occ;

    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_lane;
    logic [DEPTH-1:0] w_adv;
    logic             w_inFire;
    logic             w_outFire;

    assign w_or   = (bus.A1 & bus.A2) | bus.B | bus.C;
    assign w_lane = (INVERT != 0) ? ~w_or : w_or;

    // A stage advances if it is empty or everything downstream of it advances.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = bus.OUT_READY | ~r_v[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = ~r_v[k] | w_adv[k+1];
        end
    end

    assign w_inFire  = bus.IN_VALID & w_adv[0];
    assign w_outFire = r_v[DEPTH-1] & bus.OUT_READY;

    // Data only moves alongside a valid token, so bubbles never disturb d[].
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= bus.IN_VALID;
                if (bus.IN_VALID) begin
                    r_d[0] <= w_lane;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_d[k] <= r_d[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_occ <= '0;
        end else if (w_inFire && !w_outFire) begin
            r_occ <= r_occ + OCCW'(1);
        end else if (w_outFire && !w_inFire) begin
            r_occ <= r_occ - OCCW'(1);
        end
    end

    assign bus.IN_READY  = w_adv[0];
    assign bus.ZN        = r_d[DEPTH-1];
    assign bus.OUT_VALID = r_v[DEPTH-1];
    assign bus.OCC       = r_occ;
endmodule
